// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, frame constants and elaboration-time helpers for the UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    function automatic int clk_div(input int sys_clk_freq, input int baud_rate);
        return sys_clk_freq / baud_rate;
    endfunction

    // Bits needed to hold values 0..v-1, never less than one
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous FIFO with registered full flag and a one-cycle overflow pulse
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = clog2(DEPTH),
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, ovf_q, ovf_d;
    logic             do_push, do_pop;

    // A pop on the same edge frees the slot, so a full FIFO can still accept
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && (!full_q || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        full_d  = count_d == CW'(DEPTH);
        ovf_d   = push && !do_push;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout     = mem_q[rd_q];
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = count_q == '0;
    assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed from a small byte FIFO
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int baud_rate    = 9600,
    parameter int sys_clk_freq = 100_000_000,
    parameter int fifo_depth   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       is_transmitting,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int DIV   = clk_div(sys_clk_freq, baud_rate);
    localparam int CNT_W = clog2(DIV);
    localparam int CW    = clog2(fifo_depth + 1);

    tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 pop, empty, bit_done;
    logic [DATA_BITS-1:0] head;
    logic [CW-1:0]        fifo_count;

    uart_byte_fifo #(.WIDTH(DATA_BITS), .DEPTH(fifo_depth)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (transmit),
        .pop      (pop),
        .din      (tx_byte),
        .dout     (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (empty),
        .overflow (overflow)
    );

    assign bit_done = cnt_q == CNT_W'(DIV - 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_done ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: if (bit_done) begin
                tx_d      = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_idx_d = '0;
                state_d   = DATA;
            end
            DATA: if (bit_done) begin
                if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            // Popping at the end of the stop bit chains frames without an idle gap
            STOP: if (bit_done) begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx              = tx_q;
    assign is_transmitting = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench; a line decoder pops expected bytes as frames arrive
module tb_uart_tx_buffered;
    logic       clk = 1'b0, rst = 1'b1, transmit = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx, is_transmitting, fifo_full, overflow;
    int         n_cmp = 0, n_bad = 0, cyc = 0, ov_cnt = 0, full_cnt = 0;
    int         f0, o0, stray;
    logic [7:0] exp_q[$];
    int         starts[$];
    logic [7:0] msg [3] = '{8'h4F, 8'h4B, 8'h0A};

    uart_tx_buffered #(.baud_rate(1), .sys_clk_freq(16), .fifo_depth(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .tx              (tx),
        .is_transmitting (is_transmitting),
        .fifo_full       (fifo_full),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        ov_cnt   <= ov_cnt + int'(overflow);
        full_cnt <= full_cnt + int'(fifo_full);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        transmit = 1'b1;
        tx_byte  = b;
        tick();
        transmit = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int i;
        i = 0;
        while (is_transmitting && i < lim) begin
            tick();
            i++;
        end
        chk("idle_timeout", is_transmitting, 0);
    endtask

    task automatic mwait(input int n, inout logic ab);
        repeat (n) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
        end
    endtask

    // Line decoder: samples mid-bit (16 clocks per bit) and checks against the queue
    initial begin
        logic       prev, ab, sb, pb;
        logic [7:0] d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !tx) begin
                starts.push_back(cyc);
                ab = 1'b0;
                mwait(7, ab);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    mwait(16, ab);
                    d[i] = tx;
                end
                mwait(16, ab);
                pb = tx;
                if (!ab) begin
                    chk("start_bit", sb, 0);
                    chk("stop_bit", pb, 1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: actual %0h required none", d);
                    end else begin
                        chk("frame_data", d, exp_q.pop_front());
                    end
                end
            end
            prev = tx;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", is_transmitting, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        repeat (2) tick();

        // single byte: tx falls one edge after the push, idle 161 edges after it
        exp_q.push_back(8'h55);
        push(8'h55);
        chk("single_busy", is_transmitting, 1);
        chk("single_tx_k", tx, 1);
        tick();
        chk("single_start", tx, 0);
        repeat (159) tick();
        chk("single_stop_tx", tx, 1);
        chk("single_stop_busy", is_transmitting, 1);
        tick();
        chk("single_done_tx", tx, 1);
        chk("single_done_busy", is_transmitting, 0);

        // burst of four: never full, frames 160 clocks apart
        repeat (4) tick();
        starts.delete();
        f0 = full_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            push(8'hA0 + 8'(i));
        end
        wait_idle(1000);
        chk("burst_full", full_cnt - f0, 0);
        chk("burst_starts", starts.size(), 4);
        for (int i = 1; i < starts.size(); i++) chk("burst_spacing", starts[i] - starts[i-1], 160);

        // overflow while a frame is on the line, then push on full during the chained pop
        repeat (4) tick();
        o0 = ov_cnt;
        exp_q.push_back(8'h3C);
        push(8'h3C);
        repeat (19) tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'h10 + 8'(i));
            push(8'h10 + 8'(i));
            if (i == 3) chk("ovf_full", fifo_full, 1);
        end
        chk("ovf_pulse", overflow, 1);
        chk("ovf_full_kept", fifo_full, 1);
        tick();
        chk("ovf_pulse_end", overflow, 0);
        repeat (135) tick();
        exp_q.push_back(8'h15);
        push(8'h15);
        chk("pushpop_full", fifo_full, 1);
        chk("pushpop_ovf", overflow, 0);
        chk("pushpop_start", tx, 0);
        wait_idle(1200);
        chk("ovf_count", ov_cnt - o0, 1);

        // reset at clock 80 of a frame discards the queue and the frame
        repeat (4) tick();
        push(8'hFF);
        push(8'h77);
        repeat (79) tick();
        rst = 1'b1;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", is_transmitting, 0);
        chk("midrst_full", fifo_full, 0);
        repeat (3) tick();
        rst = 1'b0;
        stray = 0;
        repeat (200) begin
            tick();
            if (!tx) stray++;
        end
        chk("midrst_no_stray", stray, 0);
        chk("midrst_idle", is_transmitting, 0);

        // upstream handshake: pulse, wait one cycle, poll until idle
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(msg[i]);
            push(msg[i]);
            tick();
            chk("hs_busy", is_transmitting, 1);
            wait_idle(400);
        end
        repeat (4) tick();
        chk("leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Byte-serial UART transmitter with a small input FIFO. It sits directly downstream of the debug-print state machine, accepting its one-cycle `transmit` pulses and driving the board `tx` pin as 8N1 frames. The `transmit` / `tx_byte` / `is_transmitting` handshake is a drop-in for the existing transmitter. The FIFO lets a producer queue several characters without a per-character wait.

## Interface
- `baud_rate`, default 9600: line bit rate.
- `sys_clk_freq`, default 100_000_000: `clk` frequency in Hz.
- `fifo_depth`, default 4: queued bytes; power of two, 2..16.
- `clk`  in  1  master clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `transmit`  in  1  push strobe; `tx_byte` is written into the FIFO on each cycle this is high.
- `tx_byte`  in  8  data to push; sampled only when `transmit` is high.
- `tx`  out  1  serial line, registered; idle level is 1.
- `is_transmitting`  out  1  high while the FIFO is non-empty or a frame is on the line.
- `fifo_full`  out  1  FIFO holds `fifo_depth` entries.
- `overflow`  out  1  one-cycle pulse when a push is dropped.

## Operation
- Divider: DIV = sys_clk_freq / baud_rate, using integer truncation (10416 at the defaults). Each bit lasts exactly DIV clocks. The bit counter is wide enough for DIV-1.
- Frame: one start bit (0), then 8 data bits LSB first, then one stop bit (1). A frame is 10*DIV clocks.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, drive `tx`=0, and go to START.
  - START: after DIV clocks, drive bit 0 and go to DATA with bit_idx=0.
  - DATA: every DIV clocks, shift to the next bit. After bit 7 has lasted DIV clocks, drive `tx`=1 and go to STOP.
  - STOP: after DIV clocks, if the FIFO is non-empty, pop and go to START with `tx`=0 on the same edge, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- Push rules:
  - A push is accepted when the count is below `fifo_depth`, or when a pop happens on the same edge.
  - A push to a full FIFO with no pop on that edge is dropped and pulses `overflow` on the next cycle. FIFO contents are unchanged.
- Simultaneous push and pop: the count is unchanged and the pointers both advance.
- Pointers wrap modulo `fifo_depth`. The count runs 0..`fifo_depth`.
- `is_transmitting` = (state != IDLE) | (count != 0). It is decoded from registers.
- Reset values: state=IDLE, `tx`=1, count=0, pointers=0, `is_transmitting`=0, `fifo_full`=0, `overflow`=0.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronously) and queued bytes are discarded. No partial frame resumes after reset.

## Timing
- A `transmit` pulse sampled at edge k with the FIFO empty and the FSM in IDLE:
  - The FIFO is written at edge k.
  - `is_transmitting` is 1 from edge k.
  - The pop happens and `tx` falls at edge k+1.
  - The stop bit ends at edge k+1+10*DIV, where `tx`=1, state=IDLE, and `is_transmitting` falls.
- `is_transmitting` is high in the cycle after any accepted push. This keeps the upstream "pulse, wait one cycle, poll" sequence valid.
- `fifo_full` and `overflow` update on the edge that changes the count.
- Back-to-back frames: the first bit of the next frame starts exactly 10*DIV clocks after the previous start edge.

## Structure
- Shared package `uart_pkg` holds:
  - the `tx_state_t` enum (IDLE, START, DATA, STOP);
  - the constants FRAME_BITS=10 and DATA_BITS=8;
  - a `clk_div(sys_clk_freq, baud_rate)` constant function;
  - a `clog2` helper.
- Sub-module `uart_byte_fifo`: synchronous FIFO, parameterised by width and depth, with asynchronous reset. Ports: push, pop, din, dout, count, full, empty, and an overflow pulse. The top module contains the FSM, the bit counter and the shift register.

## Test plan
All scenarios use sys_clk_freq=16 and baud_rate=1, so DIV=16 and a frame is 160 clocks.
- Single byte: push 8'h55 at edge 5.
  - `tx` falls at edge 6.
  - Sampling each bit at mid-bit reads 0,1,0,1,0,1,0,1,0,1.
  - `tx`=1 and `is_transmitting`=0 at edge 166.
- Burst: push 8'hA0, 8'hA1, 8'hA2, 8'hA3 on consecutive cycles.
  - Four frames come out in order, start edges spaced exactly 160 clocks apart.
  - `fifo_full` is never set, because the first pop frees a slot before the fourth push.
- Overflow: while a frame is on the line, push 5 bytes (0x10..0x14), with `fifo_depth`=4 and no pop during those cycles.
  - 0x14 is dropped and `overflow` pulses once.
  - Only 0x10..0x13 are sent.
- Push on a full FIFO on the same cycle as the STOP-to-START pop: the push is accepted, the count stays 4, and `overflow`=0.
- Reset at clock 80 of a frame 8'hFF:
  - `tx`=1, `is_transmitting`=0 and count=0 immediately.
  - After release, `tx` stays 1 with no stray start bit.
- Upstream handshake: drive a 1-cycle `transmit` pulse, then wait 1 cycle, then poll `is_transmitting` until it reads 0, for a 3-character string "OK\n".
  - The decoded line reads 0x4F, 0x4B, 0x0A.
